// File: rtl/shifter_pkg.sv
// shifter_pkg: op encoding and per-stage control payload shared by the shifter pipeline
package shifter_pkg;
  typedef enum logic [1:0] {SHR = 2'b00, SHL = 2'b01, SRA = 2'b10, ROR = 2'b11} shift_op_t;
  typedef struct packed {
    shift_op_t op;
    logic      sign;
    logic      valid;
  } stage_ctrl_t;
endpackage

// File: rtl/shifter_stage.sv
// shifter_stage: conditional shift by DIST for the beat's op, registered with enable (ROR rotates only with SHIFTER_ROTATE_EN)
module shifter_stage import shifter_pkg::*; #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = $clog2(WIDTH),
  parameter int DIST    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               sel,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  stage_ctrl_t        in_ctrl,
  output logic [WIDTH-1:0]   out_data,
  output logic [SHAMT_W-1:0] out_shamt,
  output stage_ctrl_t        out_ctrl
);
  logic [WIDTH-1:0] ror_data;
  logic [WIDTH-1:0] next_data;
`ifdef SHIFTER_ROTATE_EN
  assign ror_data = {in_data[DIST-1:0], in_data[WIDTH-1:DIST]};
`else
  assign ror_data = in_data >> DIST;
`endif
  // select this level's shifted operand, or pass through when the shamt bit is clear
  always_comb begin
    next_data = !sel                ? in_data :
                in_ctrl.op == SHL   ? in_data << DIST :
                in_ctrl.op == SRA   ? {{DIST{in_ctrl.sign}}, in_data[WIDTH-1:DIST]} :
                in_ctrl.op == ROR   ? ror_data :
                                      in_data >> DIST;
  end
  // pipeline register; holds everything while the pipe is stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_shamt <= '0;
      out_ctrl  <= '0;
    end else if (en) begin
      out_data  <= next_data;
      out_shamt <= in_shamt;
      out_ctrl  <= in_ctrl;
    end
  end
endmodule

// File: rtl/pipelined_shifter.sv
// pipelined_shifter: log2(WIDTH)-stage barrel shifter with valid/ready; SHIFTER_ROTATE_EN enables true ROR
module pipelined_shifter import shifter_pkg::*; #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  shift_op_t          in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data
);
  logic [WIDTH-1:0]   d [SHAMT_W+1];
  logic [SHAMT_W-1:0] s [SHAMT_W+1];
  stage_ctrl_t        c [SHAMT_W+1];
  logic               unused_tail;
  assign in_ready = !out_valid || out_ready;
  assign d[0] = in_data;
  assign s[0] = in_shamt;
  assign c[0] = '{op: in_op, sign: in_data[WIDTH-1], valid: in_valid};
  for (genvar i = 0; i < SHAMT_W; i++) begin : g_stage
    shifter_stage #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W), .DIST(1 << i)) u_stage (
      .clk       (clk),
      .rst       (rst),
      .en        (in_ready),
      .sel       (s[i][i]),
      .in_data   (d[i]),
      .in_shamt  (s[i]),
      .in_ctrl   (c[i]),
      .out_data  (d[i+1]),
      .out_shamt (s[i+1]),
      .out_ctrl  (c[i+1])
    );
  end
  assign out_data    = d[SHAMT_W];
  assign out_valid   = c[SHAMT_W].valid;
  assign unused_tail = ^{s[SHAMT_W], c[SHAMT_W].op, c[SHAMT_W].sign};
endmodule

// File: tb/tb_pipelined_shifter.sv
// tb_pipelined_shifter: scoreboard-checked bench for pipelined_shifter (WIDTH=8)
module tb_pipelined_shifter;
  import shifter_pkg::*;
  localparam int W = 8;
  localparam int SW = 3;
  logic clk = 0, rst = 1, in_valid = 0, ready_reg = 1, rand_mode = 0, rnd = 1;
  logic in_ready, out_valid, out_ready;
  logic [W-1:0] in_data = '0, out_data, exp_v, held;
  logic [SW-1:0] in_shamt = '0;
  shift_op_t in_op = SHR;
  logic [W-1:0] q[$];
  int checks = 0, errors = 0, run = 0, max_run = 0;

  assign out_ready = rand_mode ? rnd : ready_reg;
  always #5 clk = ~clk;
  always @(posedge clk) rnd <= 1'($urandom);

  pipelined_shifter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_shamt(in_shamt), .in_op(in_op), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data)
  );

  function automatic logic [W-1:0] model(logic [W-1:0] d, logic [SW-1:0] s, shift_op_t op);
    logic [2*W-1:0] dd;
    dd = {d, d};
    case (op)
      SHL: return d << s;
      SRA: return W'($signed(d) >>> s);
`ifdef SHIFTER_ROTATE_EN
      ROR: return W'(dd >> s);
`endif
      default: return d >> s;
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      run = 0;
    end else begin
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL result_extra: got %h with no beat outstanding", out_data);
        end else begin
          exp_v = q.pop_front();
          if (out_data !== exp_v) begin
            errors++;
            $display("FAIL result: got %h expected %h", out_data, exp_v);
          end
        end
        run++;
        if (run > max_run) max_run = run;
      end else run = 0;
      if (in_valid && in_ready) q.push_back(model(in_data, in_shamt, in_op));
    end
  end

  task automatic send(input logic [W-1:0] d, input logic [SW-1:0] s, input shift_op_t op);
    int n = 0;
    in_valid = 1; in_data = d; in_shamt = s; in_op = op;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (n == 50) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready %b expected 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 60) begin @(posedge clk); #1; n++; end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d beats outstanding expected 0", q.size());
    end
  endtask

  task automatic expect_one(input logic [W-1:0] d, input logic [SW-1:0] s, input shift_op_t op, input logic [W-1:0] e);
    int n = 0;
    send(d, s, op);
    while (!out_valid && n < 10) begin @(posedge clk); #1; n++; end
    checks++;
    if (!out_valid || out_data !== e) begin
      errors++;
      $display("FAIL op_%s: %h sh %0d got %h valid %b expected %h", op.name(), d, s, out_data, out_valid, e);
    end
    drain();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 0 || out_data !== '0 || in_ready !== 1) begin
      errors++;
      $display("FAIL reset: valid %b data %h ready %b expected 0 00 1", out_valid, out_data, in_ready);
    end
    rst = 0;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 0 || in_ready !== 1) begin
      errors++;
      $display("FAIL post_reset: valid %b ready %b expected 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_latency();
    ready_reg = 1;
    send(8'h10, 3'd4, SHR);
    checks++;
    if (out_valid !== 0) begin errors++; $display("FAIL latency_e0: valid %b expected 0", out_valid); end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 0) begin errors++; $display("FAIL latency_e1: valid %b expected 0", out_valid); end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1 || out_data !== 8'h01) begin
      errors++;
      $display("FAIL latency_e2: valid %b data %h expected 1 01", out_valid, out_data);
    end
    drain();
  endtask

  task automatic test_ops();
    expect_one(8'h01, 3'd7, SHL, 8'h80);
    expect_one(8'h80, 3'd7, SRA, 8'hFF);
    expect_one(8'h40, 3'd2, SRA, 8'h10);
    expect_one(8'hF0, 3'd3, SRA, 8'hFE);
    expect_one(8'hB4, 3'd5, SHR, 8'h05);
`ifdef SHIFTER_ROTATE_EN
    expect_one(8'h01, 3'd1, ROR, 8'h80);
    expect_one(8'h96, 3'd4, ROR, 8'h69);
`else
    expect_one(8'h01, 3'd1, ROR, 8'h00);
    expect_one(8'h96, 3'd4, ROR, 8'h09);
`endif
    for (int k = 0; k < 4; k++) expect_one(8'hA5, 3'd0, shift_op_t'(k), 8'hA5);
  endtask

  task automatic test_back_to_back();
    ready_reg = 1;
    max_run = 0;
    for (int k = 0; k < 8; k++) send(8'($urandom), SW'($urandom_range(0, 7)), shift_op_t'($urandom_range(0, 3)));
    drain();
    checks++;
    if (max_run != 8) begin errors++; $display("FAIL back_to_back_run: %0d consecutive expected 8", max_run); end
  endtask

  task automatic test_backpressure();
    ready_reg = 0;
    send(8'h03, 3'd2, SHL);
    send(8'h81, 3'd1, SHR);
    send(8'hC0, 3'd6, SRA);
    in_valid = 1; in_data = 8'h5A; in_shamt = 3'd3; in_op = SHL;
    held = out_data;
    checks++;
    if (held !== 8'h0C || out_valid !== 1) begin
      errors++;
      $display("FAIL bp_head: data %h valid %b expected 0c 1", held, out_valid);
    end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 0 || out_valid !== 1 || out_data !== held) begin
        errors++;
        $display("FAIL bp_stall%0d: ready %b valid %b data %h expected 0 1 %h", k, in_ready, out_valid, out_data, held);
      end
    end
    ready_reg = 1;
    @(posedge clk); #1;
    in_valid = 0;
    drain();
  endtask

  task automatic test_reset_mid();
    ready_reg = 0;
    send(8'h11, 3'd1, SHL);
    send(8'h22, 3'd2, SHR);
    send(8'h33, 3'd3, SRA);
    rst = 1;
    #1;
    checks++;
    if (out_valid !== 0 || out_data !== '0 || in_ready !== 1) begin
      errors++;
      $display("FAIL reset_mid: valid %b data %h ready %b expected 0 00 1", out_valid, out_data, in_ready);
    end
    @(posedge clk); #1;
    rst = 0;
    ready_reg = 1;
    expect_one(8'h81, 3'd1, SRA, 8'hC0);
  endtask

  task automatic test_random();
    rand_mode = 1;
    for (int k = 0; k < 40; k++) send(8'($urandom), SW'($urandom_range(0, 7)), shift_op_t'($urandom_range(0, 3)));
    drain();
    rand_mode = 0;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_ops();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_random();
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
